mem_arbiter: RTL and testbench

//  Arbitrates the instruction fetch port and data memory port of the pipeline onto one single-ported RAM.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: bus word and memory arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IGNT = 2'd1,
        ARB_DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported RAM.
// Data wins by default; a streak limit forces fetch progress and a watchdog aborts stuck accesses.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ack,
    output logic        bus_err
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam int WDOG_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit WDOG_EN  = (TIMEOUT > 0);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t          state;
    arb_state_t          nxt_state;
    logic [STREAK_W-1:0] dstreak;
    logic [WDOG_W-1:0]   wdog;
    logic                grant_i;
    logic                grant_d;
    logic                abort;

    // Arbitration and grant termination
    always_comb begin
        nxt_state = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        abort     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if ((dREN || dWEN) && !(iREN && (dstreak == STREAK_MAX))) begin
                    nxt_state = ARB_DGNT;
                    grant_d   = 1'b1;
                end else if (iREN) begin
                    nxt_state = ARB_IGNT;
                    grant_i   = 1'b1;
                end
            end
            ARB_IGNT, ARB_DGNT: begin
                // An ack landing on the final watchdog cycle still completes normally.
                if (ram_ack) begin
                    nxt_state = ARB_IDLE;
                end else if (WDOG_EN && (wdog == WDOG_LAST)) begin
                    nxt_state = ARB_IDLE;
                    abort     = 1'b1;
                end
            end
            default: nxt_state = ARB_IDLE;
        endcase
    end

    // Strobes and latched address/data are registered from the next state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= ARB_IDLE;
            dstreak  <= '0;
            wdog     <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            bus_err  <= 1'b0;
        end else begin
            state   <= nxt_state;
            bus_err <= abort;
            if (grant_d) begin
                ramaddr  <= daddr;
                ramstore <= dstore;
                ramWEN   <= dWEN;
                ramREN   <= !dWEN;
                wdog     <= '0;
                if (!iREN) begin
                    dstreak <= '0;
                end else if (dstreak != STREAK_MAX) begin
                    dstreak <= dstreak + 1'b1;
                end
            end else if (grant_i) begin
                ramaddr <= iaddr;
                ramREN  <= 1'b1;
                ramWEN  <= 1'b0;
                wdog    <= '0;
                dstreak <= '0;
            end else if (nxt_state == ARB_IDLE) begin
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
            end else begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    // Hits are gated by the live request so a dropped request discards its data
    assign ihit  = (state == ARB_IGNT) && ram_ack && iREN;
    assign dhit  = (state == ARB_DGNT) && ram_ack && (dREN || dWEN);
    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ack(ram_ack), .bus_err(bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    logic        exp_i;
    logic [31:0] exp_addr;

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h40; daddr = 32'h100; dstore = 32'h0;
        ramload = 32'h0; ram_ack = 1'b1;

        // 1: reset held with every request up
        tick(); tick();
        #1;
        chk("rst_ren", {31'd0, ramREN}, 32'd0);
        chk("rst_wen", {31'd0, ramWEN}, 32'd0);
        chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("rst_berr", {31'd0, bus_err}, 32'd0);
        ram_ack = 1'b0;
        nRST = 1'b1;
        tick();
        chk("rel_dgnt_ren", {31'd0, ramREN}, 32'd1);
        chk("rel_dgnt_addr", ramaddr, 32'h100);
        chk("rel_no_hit", {30'd0, ihit, dhit}, 32'd0);
        ram_ack = 1'b1; ramload = 32'hCAFE0001;
        #1;
        chk("rel_dhit", {31'd0, dhit}, 32'd1);
        chk("rel_dload", dload, 32'hCAFE0001);
        tick();
        ram_ack = 1'b0; dREN = 1'b0; iREN = 1'b0;
        #1;
        chk("rel_idle_ren", {31'd0, ramREN}, 32'd0);

        // 2: fetch with ack three cycles after the strobe
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        chk("i_ren", {31'd0, ramREN}, 32'd1);
        chk("i_wen", {31'd0, ramWEN}, 32'd0);
        chk("i_addr", ramaddr, 32'h40);
        tick();
        chk("i_wait_hit", {31'd0, ihit}, 32'd0);
        tick();
        tick();
        ram_ack = 1'b1; ramload = 32'hDEADBEEF;
        #1;
        chk("i_hit", {31'd0, ihit}, 32'd1);
        chk("i_load", iload, 32'hDEADBEEF);
        tick();
        ram_ack = 1'b0; iREN = 1'b0;
        #1;
        chk("i_idle_ren", {31'd0, ramREN}, 32'd0);
        chk("i_idle_hit", {31'd0, ihit}, 32'd0);

        // 3: both requests held, streak limit 4
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h200;
        for (int t = 0; t < 10; t++) begin
            exp_i = (t == 4) || (t == 9);
            exp_addr = exp_i ? 32'h40 : 32'h200;
            tick();
            chk($sformatf("order_addr_%0d", t), ramaddr, exp_addr);
            tick();
            ram_ack = 1'b1;
            #1;
            chk($sformatf("order_hit_%0d", t), {30'd0, ihit, dhit}, {30'd0, exp_i, !exp_i});
            tick();
            ram_ack = 1'b0;
        end
        iREN = 1'b0; dREN = 1'b0;

        // 4: write with address and data changing mid-grant
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
        tick();
        daddr = 32'h99; dstore = 32'h0;
        #1;
        chk("w_wen", {31'd0, ramWEN}, 32'd1);
        chk("w_ren", {31'd0, ramREN}, 32'd0);
        chk("w_addr", ramaddr, 32'h80);
        chk("w_store", ramstore, 32'h12345678);
        tick();
        ram_ack = 1'b1;
        #1;
        chk("w_dhit", {31'd0, dhit}, 32'd1);
        chk("w_addr_hold", ramaddr, 32'h80);
        tick();
        ram_ack = 1'b0; dWEN = 1'b0;
        #1;
        chk("w_idle_wen", {31'd0, ramWEN}, 32'd0);

        // 5: watchdog abort after 8 grant cycles, then retry
        dREN = 1'b1; daddr = 32'h300;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("wd_ren_%0d", c), {31'd0, ramREN}, 32'd1);
            chk($sformatf("wd_berr_%0d", c), {31'd0, bus_err}, 32'd0);
        end
        chk("wd_no_hit", {31'd0, dhit}, 32'd0);
        tick();
        chk("wd_abort_ren", {31'd0, ramREN}, 32'd0);
        chk("wd_berr_pulse", {31'd0, bus_err}, 32'd1);
        tick();
        chk("wd_retry_ren", {31'd0, ramREN}, 32'd1);
        chk("wd_berr_clear", {31'd0, bus_err}, 32'd0);
        tick();
        ram_ack = 1'b1;
        #1;
        chk("wd_retry_hit", {31'd0, dhit}, 32'd1);
        tick();
        ram_ack = 1'b0; dREN = 1'b0;

        // 6: asynchronous reset two cycles into a data grant
        dREN = 1'b1; daddr = 32'h400;
        tick();
        chk("ar_grant", {31'd0, ramREN}, 32'd1);
        tick();
        nRST = 1'b0;
        #1;
        chk("ar_ren_drop", {31'd0, ramREN}, 32'd0);
        chk("ar_addr_clr", ramaddr, 32'h0);
        ram_ack = 1'b1;
        #1;
        chk("ar_no_dhit", {31'd0, dhit}, 32'd0);
        tick();
        chk("ar_held_ren", {31'd0, ramREN}, 32'd0);
        ram_ack = 1'b0; dREN = 1'b0; nRST = 1'b1;
        tick();
        chk("ar_idle_ren", {31'd0, ramREN}, 32'd0);
        iREN = 1'b1; iaddr = 32'h44;
        tick();
        chk("ar_regrant_ren", {31'd0, ramREN}, 32'd1);
        chk("ar_regrant_addr", ramaddr, 32'h44);
        tick();
        ram_ack = 1'b1;
        #1;
        chk("ar_ihit", {31'd0, ihit}, 32'd1);
        tick();
        ram_ack = 1'b0; iREN = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
